traffic_light_4way_ctrl: RTL and testbench

- Four-way intersection signal controller. It drives a fixed-time cycle: north/south green, then east/west green, then a pedestrian walk phase.
- An all-red emergency override is driven by an external request.
- Timing is counted in "ticks" from an internal clock-enable divider, so phase lengths are independent of the system clock rate.
- Sits at top level between the board clock/reset and the lamp drivers.

---
 rtl/traffic_light_4way_ctrl.sv | 159 +++++++++++++++
 tb/tb_traffic_light_4way_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_4way_ctrl.sv
// Four-way intersection controller: tick-timed NS/EW green-yellow cycle with all-red emergency override.
// Optional pedestrian walk phase after EW yellow is compiled in when PED_PHASE_EN is defined.
module traffic_light_4way_ctrl #(
  parameter int TICK_DIV     = 4,
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int PED_TICKS    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       emergency_in,
  output logic [2:0] light_north,
  output logic [2:0] light_south,
  output logic [2:0] light_east,
  output logic [2:0] light_west,
  output logic       ped_walk
);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AP    = (ALLRED_TICKS > PED_TICKS) ? ALLRED_TICKS : PED_TICKS;
  localparam int MAX_TICKS = (MAX_GY > MAX_AP) ? MAX_GY : MAX_AP;
  localparam int CNT_W     = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);
  localparam int DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED2   = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    EMERG     = 3'd6
`ifdef PED_PHASE_EN
    ,PED      = 3'd7
`endif
  } state_t;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             clk_enable;

  state_t           state_reg, state_next, succ_state;
  logic [CNT_W-1:0] phase_cnt_reg, phase_cnt_next, last_cnt;
  logic             timed;
  logic [2:0]       ns_lamp_reg, ns_lamp_next;
  logic [2:0]       ew_lamp_reg, ew_lamp_next;
  logic             ped_next;

  // Free-running tick divider; clk_enable is registered so it is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      clk_enable  <= 1'b0;
    end else begin
      if (div_cnt_reg == DIV_LAST) div_cnt_reg <= '0;
      else                         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      clk_enable <= (div_cnt_reg == DIV_LAST);
    end
  end

  // Phase length and successor of each timed state; EMERG and illegal codes are untimed.
  always_comb begin
    last_cnt   = CNT_W'(ALLRED_TICKS - 1);
    succ_state = ALLRED;
    timed      = 1'b1;
    case (state_reg)
      ALLRED:    begin last_cnt = CNT_W'(ALLRED_TICKS - 1); succ_state = NS_GREEN;  end
      NS_GREEN:  begin last_cnt = CNT_W'(GREEN_TICKS - 1);  succ_state = NS_YELLOW; end
      NS_YELLOW: begin last_cnt = CNT_W'(YELLOW_TICKS - 1); succ_state = ALLRED2;   end
      ALLRED2:   begin last_cnt = CNT_W'(ALLRED_TICKS - 1); succ_state = EW_GREEN;  end
      EW_GREEN:  begin last_cnt = CNT_W'(GREEN_TICKS - 1);  succ_state = EW_YELLOW; end
      EW_YELLOW: begin
        last_cnt = CNT_W'(YELLOW_TICKS - 1);
`ifdef PED_PHASE_EN
        succ_state = PED;
`else
        succ_state = ALLRED;
`endif
      end
`ifdef PED_PHASE_EN
      PED:       begin last_cnt = CNT_W'(PED_TICKS - 1);    succ_state = ALLRED;    end
`endif
      default:   timed = 1'b0;
    endcase
  end

  // Emergency is checked every clock and overrides any tick expiry on the same edge.
  always_comb begin
    state_next     = state_reg;
    phase_cnt_next = phase_cnt_reg;
    if (emergency_in) begin
      state_next     = EMERG;
      phase_cnt_next = '0;
    end else if (!timed) begin
      state_next     = ALLRED;
      phase_cnt_next = '0;
    end else if (clk_enable) begin
      if (phase_cnt_reg == last_cnt) begin
        state_next     = succ_state;
        phase_cnt_next = '0;
      end else begin
        phase_cnt_next = phase_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Lamp decode of the next state, registered alongside it so outputs track state_reg exactly.
  always_comb begin
    ns_lamp_next = LAMP_RED;
    ew_lamp_next = LAMP_RED;
    ped_next     = 1'b0;
    case (state_next)
      NS_GREEN:  ns_lamp_next = LAMP_GRN;
      NS_YELLOW: ns_lamp_next = LAMP_YEL;
      EW_GREEN:  ew_lamp_next = LAMP_GRN;
      EW_YELLOW: ew_lamp_next = LAMP_YEL;
`ifdef PED_PHASE_EN
      PED:       ped_next = 1'b1;
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ALLRED;
      phase_cnt_reg <= '0;
      ns_lamp_reg   <= LAMP_RED;
      ew_lamp_reg   <= LAMP_RED;
    end else begin
      state_reg     <= state_next;
      phase_cnt_reg <= phase_cnt_next;
      ns_lamp_reg   <= ns_lamp_next;
      ew_lamp_reg   <= ew_lamp_next;
    end
  end

`ifdef PED_PHASE_EN
  logic ped_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ped_reg <= 1'b0;
    else        ped_reg <= ped_next;
  end
  assign ped_walk = ped_reg;
`else
  assign ped_walk = 1'b0;
`endif

  assign light_north = ns_lamp_reg;
  assign light_south = ns_lamp_reg;
  assign light_east  = ew_lamp_reg;
  assign light_west  = ew_lamp_reg;

endmodule

// File: tb/tb_traffic_light_4way_ctrl.sv
// Directed table-driven bench for traffic_light_4way_ctrl; rows are {emergency_in, clocks, expected lamps}.
// Expectations follow the PED_PHASE_EN setting used to build the design.
module tb_traffic_light_4way_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       emergency_in;
  logic [2:0] light_north, light_south, light_east, light_west;
  logic       ped_walk;

  int checks   = 0;
  int failures = 0;
  bit monitor_on = 1'b0;

  typedef struct {
    logic       emerg;
    int         clks;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       ped;
  } vec_t;

  vec_t vecs[$];

  traffic_light_4way_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .emergency_in (emergency_in),
    .light_north  (light_north),
    .light_south  (light_south),
    .light_east   (light_east),
    .light_west   (light_west),
    .ped_walk     (ped_walk)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_row(input logic e, input int n, input logic [2:0] ns, input logic [2:0] ew, input logic p);
    vec_t v;
    v.emerg = e; v.clks = n; v.ns = ns; v.ew = ew; v.ped = p;
    vecs.push_back(v);
  endtask

  task automatic check_out(input string name, input logic [2:0] ns, input logic [2:0] ew, input logic p);
    logic [12:0] got, exp;
    got = {light_north, light_south, light_east, light_west, ped_walk};
    exp = {ns, ns, ew, ew, p};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got n/s/e/w/ped=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
               name, light_north, light_south, light_east, light_west, ped_walk, ns, ns, ew, ew, p);
    end
  endtask

  task automatic check_tick(input string name, input logic exp);
    checks++;
    if (dut.clk_enable !== exp) begin
      failures++;
      $display("FAIL %s: clk_enable got %b required %b", name, dut.clk_enable, exp);
    end
  endtask

  // Safety sweep every clock: one-hot lamps, paired directions equal, no crossing conflict.
  always @(negedge clk) begin
    if (monitor_on && rst_n) begin
      checks++;
      if (!$onehot(light_north) || !$onehot(light_east) ||
          light_north !== light_south || light_east !== light_west ||
          (light_north !== R && light_east !== R) ||
          (ped_walk === 1'b1 && (light_north !== R || light_east !== R))) begin
        failures++;
        $display("FAIL safety: n=%b s=%b e=%b w=%b ped=%b at %0t",
                 light_north, light_south, light_east, light_west, ped_walk, $time);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal cycle from the first NS green (edges counted from reset release).
    add_row(0, 20, G, R, 0);
    add_row(0,  8, Y, R, 0);
    add_row(0,  4, R, R, 0);
    add_row(0, 20, R, G, 0);
    add_row(0,  8, R, Y, 0);
`ifdef PED_PHASE_EN
    add_row(0, 12, R, R, 1);
`endif
    add_row(0,  4, R, R, 0);
    add_row(0, 20, G, R, 0);
    add_row(0,  8, Y, R, 0);
    add_row(0,  4, R, R, 0);
    // Emergency lands mid-tick in EW green and is held 10 clocks across two ticks.
    add_row(0, 10, R, G, 0);
    add_row(1,  1, R, R, 0);
    add_row(1,  9, R, R, 0);
    // Release lands on a tick edge: one full tick of all-red, then NS restarts.
    add_row(0,  4, R, R, 0);
    add_row(0, 20, G, R, 0);
    add_row(0,  8, Y, R, 0);
    add_row(0,  4, R, R, 0);
    add_row(0, 20, R, G, 0);
    add_row(0,  8, R, Y, 0);
`ifdef PED_PHASE_EN
    // Emergency mid-walk: WALK drops on the next edge.
    add_row(0,  5, R, R, 1);
    add_row(1,  1, R, R, 0);
    add_row(0,  2, R, R, 0);
`else
    add_row(0,  2, R, R, 0);
    add_row(1,  1, R, R, 0);
    add_row(0,  1, R, R, 0);
`endif
    // Emergency on the NS green expiry edge: EMERG wins over NS yellow.
    add_row(0, 20, G, R, 0);
    add_row(1,  1, R, R, 0);
    add_row(0,  3, R, R, 0);
    add_row(0,  4, G, R, 0);

    rst_n        = 1'b0;
    emergency_in = 1'b0;
    #12;
    check_out("reset_lamps", R, R, 0);
    check_tick("reset_clk_enable", 1'b0);
    #8;
    rst_n      = 1'b1;
    monitor_on = 1'b1;

    for (int k = 1; k <= 4; k++) begin
      step();
      check_tick($sformatf("first_tick_edge%0d", k), (k == 4));
      check_out($sformatf("startup_allred_edge%0d", k), R, R, 0);
    end

    for (int r = 0; r < vecs.size(); r++) begin
      $display("row %0d: emergency_in=%0b clks=%0d expect ns=%b ew=%b ped=%b",
               r, vecs[r].emerg, vecs[r].clks, vecs[r].ns, vecs[r].ew, vecs[r].ped);
      for (int c = 0; c < vecs[r].clks; c++) begin
        emergency_in = vecs[r].emerg;
        step();
        check_out($sformatf("row%0d_clk%0d", r, c), vecs[r].ns, vecs[r].ew, vecs[r].ped);
      end
    end

    // Asynchronous reset mid-green must clear outputs without a clock edge.
    emergency_in = 1'b0;
    step();
    check_out("pre_async_reset_green", G, R, 0);
    rst_n = 1'b0;
    #1;
    check_out("async_reset_lamps", R, R, 0);
    check_tick("async_reset_clk_enable", 1'b0);
    #20;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
